// File: rtl/cache_perf_cnt.sv
// Per-channel cache access/miss/max-miss-run counters with atomic snapshot
// (optionally read-and-clear) and a one-cycle-latency readout port.
module cache_perf_cnt #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 32,
  parameter bit          SAT   = 1'b1,
  parameter int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   valid,
  input  logic [NCH-1:0]   miss,
  input  logic             clear,
  input  logic             snap,
  input  logic             rd_en,
  input  logic [CH_W-1:0]  rd_ch,
  input  logic [1:0]       rd_field,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic [NCH-1:0]   ovf
);

  logic [CNT_W-1:0] acc_q [NCH];
  logic [CNT_W-1:0] mis_q [NCH];
  logic [CNT_W-1:0] run_q [NCH];
  logic [CNT_W-1:0] max_q [NCH];

  logic [CNT_W-1:0] acc_n [NCH];
  logic [CNT_W-1:0] mis_n [NCH];
  logic [CNT_W-1:0] run_n [NCH];
  logic [CNT_W-1:0] max_n [NCH];
  logic [NCH-1:0]   ovf_ev;

  logic [CNT_W-1:0] s_acc [NCH];
  logic [CNT_W-1:0] s_mis [NCH];
  logic [CNT_W-1:0] s_hit [NCH];
  logic [CNT_W-1:0] s_max [NCH];

  logic [CNT_W:0]   t_acc, t_mis, t_run;
  logic [CNT_W-1:0] rd_sel;

  // Returns {overflow, next value}; overflow means the input was all-ones.
  function automatic logic [CNT_W:0] inc(input logic [CNT_W-1:0] v);
    logic [CNT_W:0] r;
    if (&v) r = {1'b1, (SAT ? v : {CNT_W{1'b0}})};
    else    r = {1'b0, v + CNT_W'(1)};
    return r;
  endfunction

  always_comb begin
    t_acc  = '0;
    t_mis  = '0;
    t_run  = '0;
    ovf_ev = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      acc_n[i] = acc_q[i];
      mis_n[i] = mis_q[i];
      run_n[i] = run_q[i];
      max_n[i] = max_q[i];
      if (valid[i]) begin
        t_acc     = inc(acc_q[i]);
        acc_n[i]  = t_acc[CNT_W-1:0];
        ovf_ev[i] = t_acc[CNT_W];
        if (miss[i]) begin
          t_mis     = inc(mis_q[i]);
          t_run     = inc(run_q[i]);
          mis_n[i]  = t_mis[CNT_W-1:0];
          run_n[i]  = t_run[CNT_W-1:0];
          ovf_ev[i] = t_acc[CNT_W] | t_mis[CNT_W] | t_run[CNT_W];
          max_n[i]  = (t_run[CNT_W-1:0] > max_q[i]) ? t_run[CNT_W-1:0] : max_q[i];
        end else begin
          run_n[i] = '0;
        end
      end
    end
  end

  // Channel select by equality so out-of-range rd_ch falls through to zero.
  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        case (rd_field)
          2'd0:    rd_sel = s_acc[i];
          2'd1:    rd_sel = s_mis[i];
          2'd2:    rd_sel = s_hit[i];
          default: rd_sel = s_max[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
        mis_q[i] <= '0;
        run_q[i] <= '0;
        max_q[i] <= '0;
        s_acc[i] <= '0;
        s_mis[i] <= '0;
        s_hit[i] <= '0;
        s_max[i] <= '0;
      end
      ovf      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (snap) begin
          s_acc[i] <= acc_n[i];
          s_mis[i] <= mis_n[i];
          s_hit[i] <= acc_n[i] - mis_n[i];
          s_max[i] <= max_n[i];
        end
        if (clear) begin
          acc_q[i] <= '0;
          mis_q[i] <= '0;
          run_q[i] <= '0;
          max_q[i] <= '0;
        end else begin
          acc_q[i] <= acc_n[i];
          mis_q[i] <= mis_n[i];
          run_q[i] <= run_n[i];
          max_q[i] <= max_n[i];
        end
      end
      ovf      <= clear ? '0 : (ovf | ovf_ev);
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_sel;
    end
  end

endmodule

// File: tb/tb_cache_perf_cnt.sv
// Bench for cache_perf_cnt: three instances (32-bit saturating NCH=3, 4-bit
// saturating, 4-bit wrapping) against a count-based reference model.
module tb_cache_perf_cnt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, clear, snap, rd_en;
  logic [2:0] valid, miss;
  logic [1:0] rd_ch, rd_field;

  logic        rv0, rv1, rv2;
  logic [31:0] rd0;
  logic [3:0]  rd1, rd2;
  logic [2:0]  ovf0;
  logic [1:0]  ovf1, ovf2;

  cache_perf_cnt #(.NCH(3), .CNT_W(32), .SAT(1'b1)) u0 (
    .clk(clk), .reset(reset), .valid(valid), .miss(miss), .clear(clear),
    .snap(snap), .rd_en(rd_en), .rd_ch(rd_ch), .rd_field(rd_field),
    .rd_valid(rv0), .rd_data(rd0), .ovf(ovf0));

  cache_perf_cnt #(.NCH(2), .CNT_W(4), .SAT(1'b1)) u1 (
    .clk(clk), .reset(reset), .valid(valid[1:0]), .miss(miss[1:0]), .clear(clear),
    .snap(snap), .rd_en(rd_en), .rd_ch(rd_ch[0]), .rd_field(rd_field),
    .rd_valid(rv1), .rd_data(rd1), .ovf(ovf1));

  cache_perf_cnt #(.NCH(2), .CNT_W(4), .SAT(1'b0)) u2 (
    .clk(clk), .reset(reset), .valid(valid[1:0]), .miss(miss[1:0]), .clear(clear),
    .snap(snap), .rd_en(rd_en), .rd_ch(rd_ch[0]), .rd_field(rd_field),
    .rd_valid(rv2), .rd_data(rd2), .ovf(ovf2));

  int checks = 0;
  int errors = 0;

  int W [3] = '{32, 4, 4};
  bit S [3] = '{1'b1, 1'b1, 1'b0};
  int N [3] = '{3, 2, 2};

  // True event counts since the last clear/reset, plus stored snapshot values.
  longint acc_t [3][3];
  longint mis_t [3][3];
  longint run_t [3][3];
  longint lng_t [3][3];
  longint sn [3][3][4];
  longint e_data [3];
  bit     e_valid [3];

  function automatic longint lim(int d);
    return (longint'(1) << W[d]) - 1;
  endfunction

  function automatic longint fit(int d, longint x);
    if (S[d]) return (x > lim(d)) ? lim(d) : x;
    return x & lim(d);
  endfunction

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_zero();
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 3; c++) begin
        acc_t[d][c] = 0; mis_t[d][c] = 0; run_t[d][c] = 0; lng_t[d][c] = 0;
        for (int f = 0; f < 4; f++) sn[d][c][f] = 0;
      end
      e_valid[d] = 1'b0;
      e_data[d]  = 0;
    end
  endtask

  task automatic model_step(input logic [2:0] v, input logic [2:0] m, input logic clr,
                            input logic snp, input logic rst, input logic ren,
                            input logic [1:0] ch, input logic [1:0] fld);
    longint a, mi, r, l;
    int ec;
    if (rst) begin
      model_zero();
      return;
    end
    for (int d = 0; d < 3; d++) begin
      if (ren) begin
        ec = (d == 0) ? int'(ch) : int'(ch[0]);
        e_valid[d] = 1'b1;
        e_data[d]  = (ec < N[d]) ? sn[d][ec][fld] : 0;
      end else begin
        e_valid[d] = 1'b0;
      end
      for (int c = 0; c < N[d]; c++) begin
        a = acc_t[d][c]; mi = mis_t[d][c]; r = run_t[d][c]; l = lng_t[d][c];
        if (v[c]) begin
          a++;
          if (m[c]) begin
            mi++; r++;
            if (r > l) l = r;
          end else r = 0;
        end
        if (snp) begin
          sn[d][c][0] = fit(d, a);
          sn[d][c][1] = fit(d, mi);
          sn[d][c][2] = (sn[d][c][0] - sn[d][c][1]) & lim(d);
          sn[d][c][3] = (l > lim(d)) ? lim(d) : l;
        end
        if (clr) begin
          acc_t[d][c] = 0; mis_t[d][c] = 0; run_t[d][c] = 0; lng_t[d][c] = 0;
        end else begin
          acc_t[d][c] = a; mis_t[d][c] = mi; run_t[d][c] = r; lng_t[d][c] = l;
        end
      end
    end
  endtask

  task automatic check_all();
    longint ov;
    for (int d = 0; d < 3; d++) begin
      ov = 0;
      for (int c = 0; c < N[d]; c++)
        if (acc_t[d][c] > lim(d)) ov |= (longint'(1) << c);
      case (d)
        0: begin
          chk("u0_rd_valid", longint'(rv0), longint'(e_valid[0]));
          chk("u0_rd_data", longint'(rd0), e_data[0]);
          chk("u0_ovf", longint'(ovf0), ov);
        end
        1: begin
          chk("u1_rd_valid", longint'(rv1), longint'(e_valid[1]));
          chk("u1_rd_data", longint'(rd1), e_data[1]);
          chk("u1_ovf", longint'(ovf1), ov);
        end
        default: begin
          chk("u2_rd_valid", longint'(rv2), longint'(e_valid[2]));
          chk("u2_rd_data", longint'(rd2), e_data[2]);
          chk("u2_ovf", longint'(ovf2), ov);
        end
      endcase
    end
  endtask

  task automatic tick(input logic [2:0] v, input logic [2:0] m, input logic clr,
                      input logic snp, input logic rst, input logic ren,
                      input logic [1:0] ch, input logic [1:0] fld);
    valid = v; miss = m; clear = clr; snap = snp; reset = rst;
    rd_en = ren; rd_ch = ch; rd_field = fld;
    @(posedge clk);
    model_step(v, m, clr, snp, rst, ren, ch, fld);
    #1;
    check_all();
  endtask

  task automatic rd(input logic [1:0] ch, input logic [1:0] fld);
    tick(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, ch, fld);
  endtask

  task automatic idle(input logic [2:0] v, input logic [2:0] m);
    tick(v, m, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  logic [5:0] pat = 6'b101110;

  initial begin
    model_zero();
    tick(3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    tick(3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    chk("reset_ovf", longint'(ovf0), 0);

    // hit,miss,miss,miss,hit,miss on channel 0
    for (int i = 0; i < 6; i++) idle(3'b001, {2'b00, pat[i]});
    tick(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    rd(2'd0, 2'd0); chk("t1_acc", longint'(rd0), 6);
    rd(2'd0, 2'd1); chk("t1_mis", longint'(rd0), 4);
    rd(2'd0, 2'd2); chk("t1_hit", longint'(rd0), 2);
    rd(2'd0, 2'd3); chk("t1_maxrun", longint'(rd0), 3);
    for (int f = 0; f < 4; f++) begin
      rd(2'd1, 2'(f)); chk("t1_ch1", longint'(rd0), 0);
    end

    // read-and-clear with same-cycle events
    tick(3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    for (int i = 0; i < 5; i++) idle(3'b011, 3'b000);
    tick(3'b011, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    rd(2'd0, 2'd0); chk("t2_ch0_acc", longint'(rd0), 6);
    rd(2'd0, 2'd1); chk("t2_ch0_mis", longint'(rd0), 0);
    rd(2'd1, 2'd0); chk("t2_ch1_acc", longint'(rd0), 6);
    rd(2'd1, 2'd1); chk("t2_ch1_mis", longint'(rd0), 1);
    tick(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    rd(2'd0, 2'd0); chk("t2_live_zero", longint'(rd0), 0);

    // 4-bit overflow: saturating vs wrapping
    tick(3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    for (int i = 0; i < 17; i++) idle(3'b001, 3'b000);
    tick(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    rd(2'd0, 2'd0);
    chk("t3_sat_acc", longint'(rd1), 15);
    chk("t3_wrap_acc", longint'(rd2), 1);
    chk("t3_sat_ovf", longint'(ovf1[0]), 1);
    chk("t3_wrap_ovf", longint'(ovf2[0]), 1);
    tick(3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    chk("t3_clr_ovf", longint'(ovf1[0]), 0);

    // clear drops same-cycle event
    tick(3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    tick(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    rd(2'd0, 2'd0); chk("t4_acc", longint'(rd0), 0);

    // out-of-range channel, then read concurrent with snap
    rd(2'd3, 2'd0);
    chk("t5_oor_valid", longint'(rv0), 1);
    chk("t5_oor_data", longint'(rd0), 0);
    for (int i = 0; i < 3; i++) idle(3'b001, 3'b000);
    tick(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
    chk("t5_old_snap", longint'(rd0), 0);
    rd(2'd0, 2'd0); chk("t5_new_snap", longint'(rd0), 3);

    // reset mid-traffic with a read in flight
    idle(3'b111, 3'b101);
    tick(3'b111, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    tick(3'b111, 3'b110, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0);
    chk("t6_rv", longint'(rv0), 0);
    chk("t6_ovf", longint'(ovf0), 0);
    rd(2'd0, 2'd0); chk("t6_acc0", longint'(rd0), 0);
    rd(2'd2, 2'd1); chk("t6_mis2", longint'(rd0), 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      tick(3'($urandom), 3'($urandom), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0),
           1'($urandom), 2'($urandom), 2'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_perf_cnt.md
# cache_perf_cnt

Parametrised hardware cache performance counter bank for the RVNoob core, covering I-cache, D-cache and any further cache channels. It sits beside the cache controllers and consumes one access/miss strobe pair per channel. Per channel it keeps access, miss and longest-consecutive-miss-run counters, with selectable saturating or wrapping arithmetic and sticky overflow flags. An atomic snapshot (optionally read-and-clear) feeds a one-cycle-latency readout port, so statistics are available to the simulation harness and to CSR logic without per-access DPI calls.

## Interface
Parameters:
- NCH, 2, number of cache channels (≥1); channel 0 = ICache, 1 = DCache by convention
- CNT_W, 32, width of every counter and of rd_data (≥4)
- SAT, 1, 1 = counters saturate at all-ones; 0 = counters wrap to 0
- CH_W, max(1, clog2(NCH)), width of rd_ch

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- valid  in  NCH  bit i = channel i access completed this cycle
- miss  in  NCH  bit i = that access missed; ignored when valid[i]=0
- clear  in  1  zero live counters, run trackers and ovf
- snap  in  1  copy live state of all channels into snapshot registers
- rd_en  in  1  read request
- rd_ch  in  CH_W  channel to read
- rd_field  in  2  0 = accesses, 1 = misses, 2 = hits, 3 = max miss run
- rd_valid  out  1  rd_data valid (one-cycle pulse)
- rd_data  out  CNT_W  read result
- ovf  out  NCH  sticky live overflow flag per channel

## Operation
- Live state per channel i: acc[i], mis[i], run[i] (current consecutive-miss run), maxrun[i]; all CNT_W bits.
- Live update (next-state) per cycle:
  - valid=1, miss=0: acc+1; run←0.
  - valid=1, miss=1: acc+1; mis+1; run+1; maxrun←max(maxrun, run+1).
  - valid=0: no change.
- Overflow, all counters (acc, mis, run, maxrun):
  - An increment from all-ones holds at all-ones when SAT=1 and gives 0 when SAT=0.
  - Either case sets ovf[i], which stays set until clear or reset.
- Snapshot state per channel: s_acc, s_mis, s_maxrun; s_hit = s_acc − s_mis mod 2^CNT_W, computed at snap time and stored.
- snap=1: each snapshot register loads the live next-state, i.e. it includes this cycle's events.
- clear=1 without snap: live next-state is 0 for every channel and this cycle's events are dropped. Snapshot registers are untouched.
- snap=1 and clear=1 together (read-and-clear): the snapshot includes this cycle's events, and live state goes to 0. No event is lost or double counted.
- Readout:
  - rd_en sampled at cycle N gives rd_valid=1 at N+1, with rd_data = snapshot[rd_ch][rd_field] as registered at the end of cycle N. A snap in cycle N is not visible to that read.
  - rd_ch ≥ NCH returns rd_data=0 with rd_valid=1.
  - rd_data holds its value until the next rd_valid.
- Channels are fully independent; simultaneous strobes on all channels are counted in the same cycle.

## Timing
- Reset: all live counters, snapshot registers, ovf, rd_valid and rd_data are 0 in the cycle after reset is sampled high. reset overrides clear, snap and rd_en. A read in flight when reset asserts is dropped: rd_valid=0.
- Counter update latency is 1 cycle: a strobe at edge N is reflected in the live counters after edge N.
- Read latency is 1 cycle. rd_en may be high every cycle, giving back-to-back reads.
- No stalls and no backpressure; every input is sampled every cycle.

## Test plan
- Reset, then drive channel 0 with pattern hit,miss,miss,miss,hit,miss; then snap; then read fields 0..3 of ch 0. Required: rd_data = 6, 4, 2, 3, each with rd_valid one cycle after its rd_en. Ch 1 reads all 0.
- Assert valid=2'b11, miss=2'b10 on the same cycle as snap=1 and clear=1, with prior live acc=5 on both channels. Required snapshot: ch0 acc=6, mis=0; ch1 acc=6, mis=1. Live state reads 0 after a second snap with no traffic.
- Set CNT_W=4, SAT=1; issue 17 accesses on ch 0; snap. Required: acc=15, ovf[0]=1. With SAT=0, acc=1 and ovf[0]=1. A clear then drops ovf[0] to 0.
- Clear alone on the same cycle as valid[0]=1: snap next cycle, then read acc. Required: 0.
- rd_en with rd_ch=NCH (e.g. NCH=3, rd_ch=3). Required: rd_valid=1, rd_data=0. Then rd_en and snap in the same cycle: read returns the old snapshot value.
- Assert reset mid-traffic with rd_en high. Required: next cycle rd_valid=0, ovf=0, and all subsequent reads 0 until new events are snapped.
